seg_score_decoder: RTL and testbench
====================================

SEG_SCORE_DECODER -- requirements
Module: seg_score_decoder

Interface
REQ-001 Parameter: WIN_SCORE, default 7, winning score, legal range 1..7.
REQ-002 clock  input  1  single clock; all flops on posedge clock.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on posedge clock.
REQ-004 score_l  input  7  left player active-low seven-segment code, bit order g..a.
REQ-005 score_r  input  7  right player seven-segment code, same format.
REQ-006 value_l  output  3  decoded left score, 0..7.
REQ-007 value_r  output  3  decoded right score, 0..7.
REQ-008 inc_l  output  1  one-cycle pulse when left score advances by exactly 1.
REQ-009 inc_r  output  1  one-cycle pulse when right score advances by exactly 1.
REQ-010 winner  output  2  00 none, 01 left, 10 right, 11 tie.
REQ-011 game_over  output  1  high while the FSM is in a win or tie state.
REQ-012 err  output  1  sticky fault: illegal segment code or illegal score jump.

Function
REQ-013 Codes: 1111111=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7; any other code is illegal.
REQ-014 Inputs are registered once; decode acts on the registered codes; all outputs are registered, so an input change appears on value_x two clocks later.
REQ-015 Each side keeps the previous decoded value; new == prev+1 gives an inc_x pulse for one cycle.
REQ-016 new == prev gives no pulse; new == 0 from any nonzero value is a game restart: no pulse, no error.
REQ-017 Any other change (skip, decrement to nonzero, 7 to nonzero) sets err; the value still updates and no pulse is issued.
REQ-018 An illegal code sets err and holds value_x and prev at the last legal value.
REQ-019 FSM states: PLAY, WIN_L, WIN_R, TIE.
REQ-020 PLAY to WIN_L when value_l reaches WIN_SCORE and value_r does not, in the same cycle.
REQ-021 PLAY to WIN_R when value_r reaches WIN_SCORE and value_l does not, in the same cycle.
REQ-022 PLAY to TIE when both sides reach WIN_SCORE in the same cycle.
REQ-023 WIN_L, WIN_R and TIE return to PLAY only when both decoded values are 0; otherwise they hold, and further incs are still reported.
REQ-024 winner and game_over change on the same clock as the value update that caused the transition.
REQ-025 err clears only on reset.

Reset
REQ-026 While reset is low: input registers load 1111111, prev and value_x = 0, inc_x = 0, winner = 00, game_over = 0, err = 0, FSM = PLAY.
REQ-027 Reset mid-game discards all history; the first legal code after release is compared against 0.

Configuration
REQ-028 With SEG_SCORE_ERR_EN defined: illegal-code and illegal-jump detection drive err as in REQ-017, REQ-018 and REQ-025.
REQ-029 Without SEG_SCORE_ERR_EN: err is tied 0; illegal codes hold the last value silently; illegal jumps update the value silently.

Structure
REQ-030 Package seg_score_pkg holds: the FSM state enum, the eight segment-code localparams, and the winner encoding localparams.
REQ-031 Sub-module seg7_to_bin is combinational, code in, {legal, value[2:0]} out, and is instantiated twice.

Verification
REQ-032 Reset low 2 cycles then high, inputs 1111111 -> value_l = value_r = 0, winner = 00, err = 0.
REQ-033 score_l steps 0..7, one new code every 4 cycles -> seven inc_l pulses, each 1 cycle; value_l = 7; winner = 01 and game_over = 1 two clocks after code 1111000.
REQ-034 Both sides at 6, then both 1111000 on the same clock -> winner = 11; both then 1111111 -> PLAY, winner = 00.
REQ-035 score_r jumps 0100100 (2) to 0010010 (5) with SEG_SCORE_ERR_EN -> err = 1, value_r = 5, no inc_r; err stays 1 until reset.
REQ-036 score_l = 1010101 (illegal) -> value_l holds its prior value; err = 1 with the macro, err = 0 without it.
REQ-037 WIN_SCORE = 3, left reaches 3 -> winner = 01; reset asserted mid-hold -> all outputs at reset values next clock.

Source files
------------

// File: rtl/seg_score_pkg.sv
`default_nettype none
//==============================================================================
// seg_score_pkg: shared FSM states, segment codes and winner encodings
// Rev 1.0
//==============================================================================
package seg_score_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_WIN_L = 2'd1,
    ST_WIN_R = 2'd2,
    ST_TIE   = 2'd3
  } state_e;

  // Active-low seven-segment codes, bit order g..a
  localparam logic [6:0] c_seg_0 = 7'b1111111;
  localparam logic [6:0] c_seg_1 = 7'b1111001;
  localparam logic [6:0] c_seg_2 = 7'b0100100;
  localparam logic [6:0] c_seg_3 = 7'b0110000;
  localparam logic [6:0] c_seg_4 = 7'b0011001;
  localparam logic [6:0] c_seg_5 = 7'b0010010;
  localparam logic [6:0] c_seg_6 = 7'b0000010;
  localparam logic [6:0] c_seg_7 = 7'b1111000;

  localparam logic [1:0] c_winner_none  = 2'b00;
  localparam logic [1:0] c_winner_left  = 2'b01;
  localparam logic [1:0] c_winner_right = 2'b10;
  localparam logic [1:0] c_winner_tie   = 2'b11;

  typedef struct packed {
    logic [2:0] value;
    logic       inc;
    logic       bad_code;
    logic       bad_jump;
  } side_t;

  // Next value and events for one side, given its decoded {legal, value} and the previous value
  function automatic side_t side_next(input logic [3:0] dec, input logic [2:0] prev);
    side_t s;
    s.value    = prev;
    s.inc      = 1'b0;
    s.bad_code = 1'b0;
    s.bad_jump = 1'b0;
    if (!dec[3]) begin
      s.bad_code = 1'b1;
    end else begin
      s.value = dec[2:0];
      if (dec[2:0] != prev) begin
        if ({1'b0, dec[2:0]} == ({1'b0, prev} + 4'd1)) begin
          s.inc = 1'b1;
        end else if (dec[2:0] != 3'd0) begin
          s.bad_jump = 1'b1;
        end
      end
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_to_bin.sv
`default_nettype none
//==============================================================================
// seg7_to_bin: combinational seven-segment to binary decoder, out = {legal, value}
// Rev 1.0
//==============================================================================
module seg7_to_bin
  import seg_score_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] dec
);

  always_comb begin
    dec = 4'b0000;
    case (code)
      c_seg_0: dec = {1'b1, 3'd0};
      c_seg_1: dec = {1'b1, 3'd1};
      c_seg_2: dec = {1'b1, 3'd2};
      c_seg_3: dec = {1'b1, 3'd3};
      c_seg_4: dec = {1'b1, 3'd4};
      c_seg_5: dec = {1'b1, 3'd5};
      c_seg_6: dec = {1'b1, 3'd6};
      c_seg_7: dec = {1'b1, 3'd7};
      default: dec = 4'b0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_score_decoder.sv
`default_nettype none
//==============================================================================
// seg_score_decoder: two-player seven-segment score tracker with win FSM;
// define SEG_SCORE_ERR_EN to enable the sticky err output.  Rev 1.0
//==============================================================================
module seg_score_decoder
  import seg_score_pkg::*;
#(
  parameter int WIN_SCORE = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] score_l,
  input  logic [6:0] score_r,
  output logic [2:0] value_l,
  output logic [2:0] value_r,
  output logic       inc_l,
  output logic       inc_r,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       err
);

  localparam logic [2:0] c_win = 3'(WIN_SCORE);

  logic [6:0] score_l_q, score_l_d;
  logic [6:0] score_r_q, score_r_d;
  logic [2:0] value_l_q, value_l_d;
  logic [2:0] value_r_q, value_r_d;
  logic       inc_l_q, inc_l_d;
  logic       inc_r_q, inc_r_d;
  logic [1:0] winner_q, winner_d;
  logic       game_over_q, game_over_d;
  state_e     state_q, state_d;

  logic [3:0] dec_l, dec_r;
  side_t      side_l, side_r;
  logic       win_l, win_r;

  seg7_to_bin u_dec_l (
    .code (score_l_q),
    .dec  (dec_l)
  );

  seg7_to_bin u_dec_r (
    .code (score_r_q),
    .dec  (dec_r)
  );

  // The registered value doubles as the "previous" value for jump checking
  always_comb begin
    score_l_d = score_l;
    score_r_d = score_r;
    side_l    = side_next(dec_l, value_l_q);
    side_r    = side_next(dec_r, value_r_q);
    value_l_d = side_l.value;
    value_r_d = side_r.value;
    inc_l_d   = side_l.inc;
    inc_r_d   = side_r.inc;
    win_l     = (value_l_d == c_win);
    win_r     = (value_r_d == c_win);
  end

  // FSM looks at the next values so winner moves on the same clock as the score
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PLAY: begin
        if (win_l && win_r) begin
          state_d = ST_TIE;
        end else if (win_l) begin
          state_d = ST_WIN_L;
        end else if (win_r) begin
          state_d = ST_WIN_R;
        end
      end
      default: begin
        if ((value_l_d == 3'd0) && (value_r_d == 3'd0)) begin
          state_d = ST_PLAY;
        end
      end
    endcase
  end

  always_comb begin
    winner_d    = c_winner_none;
    game_over_d = 1'b0;
    case (state_d)
      ST_WIN_L: begin
        winner_d    = c_winner_left;
        game_over_d = 1'b1;
      end
      ST_WIN_R: begin
        winner_d    = c_winner_right;
        game_over_d = 1'b1;
      end
      ST_TIE: begin
        winner_d    = c_winner_tie;
        game_over_d = 1'b1;
      end
      default: begin
        winner_d    = c_winner_none;
        game_over_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      score_l_q   <= c_seg_0;
      score_r_q   <= c_seg_0;
      value_l_q   <= 3'd0;
      value_r_q   <= 3'd0;
      inc_l_q     <= 1'b0;
      inc_r_q     <= 1'b0;
      winner_q    <= c_winner_none;
      game_over_q <= 1'b0;
      state_q     <= ST_PLAY;
    end else begin
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      value_l_q   <= value_l_d;
      value_r_q   <= value_r_d;
      inc_l_q     <= inc_l_d;
      inc_r_q     <= inc_r_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      state_q     <= state_d;
    end
  end

  assign value_l   = value_l_q;
  assign value_r   = value_r_q;
  assign inc_l     = inc_l_q;
  assign inc_r     = inc_r_q;
  assign winner    = winner_q;
  assign game_over = game_over_q;

`ifdef SEG_SCORE_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | side_l.bad_code | side_l.bad_jump | side_r.bad_code | side_r.bad_jump;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_fault;
  assign unused_fault = side_l.bad_code | side_l.bad_jump | side_r.bad_code | side_r.bad_jump;
  assign err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_score_decoder.sv
`default_nettype none
//==============================================================================
// tb_seg_score_decoder: directed stimulus with queued expectations and a monitor
// Rev 1.0
//==============================================================================
module tb_seg_score_decoder;

`ifdef SEG_SCORE_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] score_l = 7'b1111111;
  logic [6:0] score_r = 7'b1111111;

  logic [2:0] a_vl, a_vr, b_vl, b_vr;
  logic       a_il, a_ir, b_il, b_ir;
  logic [1:0] a_w, b_w;
  logic       a_go, b_go, a_err, b_err;

  seg_score_decoder #(.WIN_SCORE(7)) dut7 (
    .clock(clock), .reset(reset), .score_l(score_l), .score_r(score_r),
    .value_l(a_vl), .value_r(a_vr), .inc_l(a_il), .inc_r(a_ir),
    .winner(a_w), .game_over(a_go), .err(a_err)
  );

  seg_score_decoder #(.WIN_SCORE(3)) dut3 (
    .clock(clock), .reset(reset), .score_l(score_l), .score_r(score_r),
    .value_l(b_vl), .value_r(b_vr), .inc_l(b_il), .inc_r(b_ir),
    .winner(b_w), .game_over(b_go), .err(b_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  wire [11:0] got7 = {a_vl, a_vr, a_il, a_ir, a_w, a_go, a_err};
  wire [11:0] got3 = {b_vl, b_vr, b_il, b_ir, b_w, b_go, b_err};

  typedef struct {
    int          cyc;
    bit          sel3;
    logic [11:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] seg [8] = '{7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  // Monitor: every expectation carries the cycle at which the DUT must present it
  always @(negedge clock) begin
    exp_t        e;
    logic [11:0] got;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e   = sbq.pop_front();
      got = e.sel3 ? got3 : got7;
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d reached at cycle %0d", e.name, e.cyc, cyc);
      end else if (got !== e.exp) begin
        n_bad++;
        $display("FAIL %s (dut%0d cyc %0d): {vl,vr,il,ir,win,go,err} got %b want %b",
                 e.name, e.sel3 ? 3 : 7, cyc, got, e.exp);
      end
    end
  end

  task automatic push(input int dly, input bit s3, input string nm,
                      input logic [2:0] vl, input logic [2:0] vr, input logic il, input logic ir,
                      input logic [1:0] w, input logic go, input logic e);
    exp_t x;
    x.cyc  = cyc + dly;
    x.sel3 = s3;
    x.exp  = {vl, vr, il, ir, w, go, e};
    x.name = nm;
    sbq.push_back(x);
  endtask

  // New codes every 4 cycles; values land two clocks after the drive edge
  task automatic step(input string nm, input logic [6:0] l, input logic [6:0] r, input bit s3,
                      input logic [2:0] vl, input logic [2:0] vr, input logic il, input logic ir,
                      input logic [1:0] w, input logic go, input logic e);
    @(negedge clock);
    score_l = l;
    score_r = r;
    push(2, s3, nm, vl, vr, il, ir, w, go, e);
    if (il || ir) push(3, s3, {nm, "_pulse_end"}, vl, vr, 1'b0, 1'b0, w, go, e);
    repeat (3) @(negedge clock);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clock);
    reset   = 1'b0;
    score_l = seg[0];
    score_r = seg[0];
    push(1, 1'b0, {nm, "_asserted7"}, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    push(1, 1'b1, {nm, "_asserted3"}, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    push(2, 1'b0, {nm, "_released7"}, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    push(2, 1'b1, {nm, "_released3"}, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    do_reset("reset");

    // Left counts 0..7 alone
    for (int k = 1; k <= 7; k++) begin
      step($sformatf("l_step%0d", k), seg[k], seg[0], 1'b0, 3'(k), 3'd0, 1'b1, 1'b0,
           (k == 7) ? 2'b01 : 2'b00, (k == 7), 1'b0);
    end
    step("restart", seg[0], seg[0], 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // Both count together to a tie
    for (int k = 1; k <= 6; k++) begin
      step($sformatf("both_step%0d", k), seg[k], seg[k], 1'b0, 3'(k), 3'(k), 1'b1, 1'b1,
           2'b00, 1'b0, 1'b0);
    end
    step("tie", seg[7], seg[7], 1'b0, 3'd7, 3'd7, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
    step("tie_clear", seg[0], seg[0], 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // Illegal code holds the value
    step("l_one", seg[1], seg[0], 1'b0, 3'd1, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step("l_illegal", 7'b1010101, seg[0], 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, ERR);
    step("l_back", seg[1], seg[0], 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, ERR);
    step("l_two", seg[2], seg[0], 1'b0, 3'd2, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, ERR);

    // Illegal jumps on the right
    do_reset("reset_mid");
    step("r_one", seg[0], seg[1], 1'b0, 3'd0, 3'd1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    step("r_two", seg[0], seg[2], 1'b0, 3'd0, 3'd2, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    step("r_skip", seg[0], seg[5], 1'b0, 3'd0, 3'd5, 1'b0, 1'b0, 2'b00, 1'b0, ERR);
    step("r_dec", seg[0], seg[3], 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 2'b00, 1'b0, ERR);
    step("r_hold", seg[0], seg[3], 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 2'b00, 1'b0, ERR);
    do_reset("reset_clr");

    // WIN_SCORE = 3 instance
    step("w3_l1", seg[1], seg[0], 1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step("w3_l2", seg[2], seg[0], 1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    step("w3_l3", seg[3], seg[0], 1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
    step("w3_l4", seg[4], seg[0], 1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
    do_reset("w3_reset_hold");

    // History discarded: first code after reset compares against 0
    step("post_reset_l1", seg[1], seg[0], 1'b0, 3'd1, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge clock);
    if (sbq.size() > 0) begin
      $display("FAIL drain: %0d expectations never reached", sbq.size());
      $fatal(1, "scoreboard did not drain");
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
